rrat_retire_ckpt: RTL and testbench

Parametrised retirement register alias table for the N-wide out-of-order core. It commits up to SCALAR architectural-to-physical mappings per cycle and returns each superseded physical tag to the free list one cycle later. On rollback it captures a registered snapshot of the committed map for the front-end RAT, delivered through a valid/ready handshake. It sits between the ROB retire stage and the RAT/free-list pair.

---
 rtl/rrat_retire_ckpt_pkg.sv | 24 ++
 rtl/rrat_retire_ckpt_chain.sv | 39 +++
 rtl/rrat_retire_ckpt.sv | 85 ++++++++
 tb/tb_rrat_retire_ckpt.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rrat_retire_ckpt_pkg.sv
// Shared types for the retirement RAT: retire lane, freed-tag record, FSM state.
// Field widths are capacities; the top zero-extends its narrower ports into them.
package rrat_pkg;

  localparam int unsigned AREG_IDX_WIDTH  = 6;
  localparam int unsigned TAG_FIELD_WIDTH = 8;

  typedef struct packed {
    logic                       en;
    logic [AREG_IDX_WIDTH-1:0]  areg;
    logic [TAG_FIELD_WIDTH-1:0] tag;
  } rrat_retire_t;

  typedef struct packed {
    logic                       valid;
    logic [TAG_FIELD_WIDTH-1:0] tag;
  } rrat_free_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rrat_state_e;

endpackage

// File: rtl/rrat_retire_ckpt_chain.sv
// Combinational retire chain: applies lanes oldest-first to the committed map.
// Optional RRAT_ZERO_REG_EN: writes to architectural register 0 are dropped.
module rrat_retire_chain
  import rrat_pkg::*;
#(
  parameter int unsigned SCALAR         = 2,
  parameter int unsigned NUM_ARCH_REGS  = 32,
  parameter int unsigned PREG_IDX_WIDTH = 6
) (
  input  logic         [NUM_ARCH_REGS-1:0][PREG_IDX_WIDTH-1:0] cur_map,
  input  rrat_retire_t [SCALAR-1:0]                            lanes,
  output logic         [NUM_ARCH_REGS-1:0][PREG_IDX_WIDTH-1:0] next_map,
  output rrat_free_t   [SCALAR-1:0]                            frees
);

  localparam int unsigned AW = $clog2(NUM_ARCH_REGS);

  logic [SCALAR-1:0] live;

  // Walking lanes in order gives both the intra-group forwarding of freed
  // tags and youngest-lane-wins on the final map.
  always_comb begin
    next_map = cur_map;
    live     = '0;
    for (int unsigned j = 0; j < SCALAR; j++) begin
      frees[j] = '0;
      live[j]  = lanes[j].en;
`ifdef RRAT_ZERO_REG_EN
      if (lanes[j].areg == '0) live[j] = 1'b0;
`endif
      if (live[j]) begin
        frees[j].valid = 1'b1;
        frees[j].tag   = TAG_FIELD_WIDTH'(next_map[lanes[j].areg[AW-1:0]]);
        next_map[lanes[j].areg[AW-1:0]] = lanes[j].tag[PREG_IDX_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/rrat_retire_ckpt.sv
// Retirement RAT with freed-tag return and rollback snapshot handshake.
// Optional macro RRAT_ZERO_REG_EN hardwires architectural register 0 to tag 0.
module rrat_retire_ckpt
  import rrat_pkg::*;
#(
  parameter int unsigned SCALAR         = 2,
  parameter int unsigned NUM_ARCH_REGS  = 32,
  parameter int unsigned PREG_IDX_WIDTH = 6
) (
  input  logic                                                clock,
  input  logic                                                reset_n,
  input  logic [SCALAR-1:0]                                   retire_en,
  input  logic [SCALAR-1:0][$clog2(NUM_ARCH_REGS)-1:0]        retire_areg,
  input  logic [SCALAR-1:0][PREG_IDX_WIDTH-1:0]               retire_tag,
  output logic                                                retire_stall,
  output logic [SCALAR-1:0]                                   free_valid,
  output logic [SCALAR-1:0][PREG_IDX_WIDTH-1:0]               free_tag,
  input  logic                                                rollback,
  output logic                                                copy_valid,
  input  logic                                                copy_ready,
  output logic [NUM_ARCH_REGS-1:0][PREG_IDX_WIDTH-1:0]        copy_map
);

  if (NUM_ARCH_REGS > (1 << AREG_IDX_WIDTH)) begin : g_areg_chk
    $error("NUM_ARCH_REGS exceeds rrat_pkg areg field capacity");
  end
  if (PREG_IDX_WIDTH > TAG_FIELD_WIDTH || PREG_IDX_WIDTH < $clog2(NUM_ARCH_REGS)) begin : g_tag_chk
    $error("PREG_IDX_WIDTH out of range");
  end

  rrat_state_e                                  state;
  logic [NUM_ARCH_REGS-1:0][PREG_IDX_WIDTH-1:0] map_q;
  logic [NUM_ARCH_REGS-1:0][PREG_IDX_WIDTH-1:0] map_d;
  rrat_retire_t [SCALAR-1:0]                    lanes;
  rrat_free_t   [SCALAR-1:0]                    frees;

  always_comb begin
    for (int unsigned j = 0; j < SCALAR; j++) begin
      lanes[j].en   = retire_en[j] && (state == IDLE);
      lanes[j].areg = AREG_IDX_WIDTH'(retire_areg[j]);
      lanes[j].tag  = TAG_FIELD_WIDTH'(retire_tag[j]);
    end
  end

  rrat_retire_chain #(
    .SCALAR         (SCALAR),
    .NUM_ARCH_REGS  (NUM_ARCH_REGS),
    .PREG_IDX_WIDTH (PREG_IDX_WIDTH)
  ) u_chain (
    .cur_map  (map_q),
    .lanes    (lanes),
    .next_map (map_d),
    .frees    (frees)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      free_valid <= '0;
      free_tag   <= '0;
      for (int unsigned i = 0; i < NUM_ARCH_REGS; i++) begin
        map_q[i]    <= PREG_IDX_WIDTH'(i);
        copy_map[i] <= PREG_IDX_WIDTH'(i);
      end
    end else begin
      map_q <= map_d;
      for (int unsigned j = 0; j < SCALAR; j++) begin
        free_valid[j] <= frees[j].valid;
        free_tag[j]   <= frees[j].tag[PREG_IDX_WIDTH-1:0];
      end
      case (state)
        IDLE: if (rollback) begin
          copy_map <= map_d;
          state    <= HOLD;
        end
        HOLD: if (copy_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign retire_stall = (state == HOLD);
  assign copy_valid   = (state == HOLD);

endmodule

// File: tb/tb_rrat_retire_ckpt.sv
// Directed and model-driven checks for rrat_retire_ckpt at SCALAR=4.
module tb_rrat_retire_ckpt;

  localparam int SC = 4;
  localparam int NA = 32;
  localparam int PW = 6;
  localparam int AW = 5;

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b0;
  logic [SC-1:0]          retire_en = '0;
  logic [SC-1:0][AW-1:0]  retire_areg = '0;
  logic [SC-1:0][PW-1:0]  retire_tag = '0;
  logic                   retire_stall;
  logic [SC-1:0]          free_valid;
  logic [SC-1:0][PW-1:0]  free_tag;
  logic                   rollback = 1'b0;
  logic                   copy_valid;
  logic                   copy_ready = 1'b0;
  logic [NA-1:0][PW-1:0]  copy_map;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rrat_retire_ckpt #(
    .SCALAR         (SC),
    .NUM_ARCH_REGS  (NA),
    .PREG_IDX_WIDTH (PW)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .retire_en    (retire_en),
    .retire_areg  (retire_areg),
    .retire_tag   (retire_tag),
    .retire_stall (retire_stall),
    .free_valid   (free_valid),
    .free_tag     (free_tag),
    .rollback     (rollback),
    .copy_valid   (copy_valid),
    .copy_ready   (copy_ready),
    .copy_map     (copy_map)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    retire_en   = '0;
    retire_areg = '0;
    retire_tag  = '0;
    rollback    = 1'b0;
  endtask

  task automatic lane(input int j, input int a, input int t);
    retire_en[j]   = 1'b1;
    retire_areg[j] = AW'(a);
    retire_tag[j]  = PW'(t);
  endtask

  task automatic do_reset();
    clr();
    copy_ready = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    checks++; if (retire_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", retire_stall); end
    checks++; if (free_valid !== 4'b0000) begin errors++; $display("FAIL reset_fv got %b want 0000", free_valid); end
    checks++; if (free_tag !== '0) begin errors++; $display("FAIL reset_ftag got %h want 0", free_tag); end
    checks++; if (copy_valid !== 1'b0) begin errors++; $display("FAIL reset_cv got %b want 0", copy_valid); end
    bad = 0;
    for (int i = 0; i < NA; i++) if (copy_map[i] !== PW'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL reset_copy_map got %0d non-identity entries want 0", bad); end
  endtask

  task automatic test_single();
    clr(); lane(0, 3, 40); step();
    checks++; if (free_valid !== 4'b0001) begin errors++; $display("FAIL single_fv got %b want 0001", free_valid); end
    checks++; if (free_tag[0] !== 6'd3) begin errors++; $display("FAIL single_ftag got %0d want 3", free_tag[0]); end
    clr(); step();
    checks++; if (free_valid !== 4'b0000) begin errors++; $display("FAIL idle_fv got %b want 0000", free_valid); end
    lane(0, 3, 41); step();
    checks++; if (free_tag[0] !== 6'd40) begin errors++; $display("FAIL single_map3 got %0d want 40", free_tag[0]); end
    clr();
  endtask

  task automatic test_same_reg();
    clr(); lane(0, 5, 33); lane(1, 5, 34); step();
    checks++; if (free_valid !== 4'b0011) begin errors++; $display("FAIL same_fv got %b want 0011", free_valid); end
    checks++; if (free_tag[0] !== 6'd5) begin errors++; $display("FAIL same_ftag0 got %0d want 5", free_tag[0]); end
    checks++; if (free_tag[1] !== 6'd33) begin errors++; $display("FAIL same_ftag1 got %0d want 33", free_tag[1]); end
    clr(); lane(2, 5, 35); step();
    checks++; if (free_valid !== 4'b0100) begin errors++; $display("FAIL same_fv2 got %b want 0100", free_valid); end
    checks++; if (free_tag[2] !== 6'd34) begin errors++; $display("FAIL same_youngest got %0d want 34", free_tag[2]); end
    clr();
  endtask

  task automatic test_rollback();
    logic [NA-1:0][PW-1:0] snap;
    clr(); lane(1, 7, 50); rollback = 1'b1; copy_ready = 1'b0; step();
    checks++; if (copy_valid !== 1'b1) begin errors++; $display("FAIL rb_cv got %b want 1", copy_valid); end
    checks++; if (retire_stall !== 1'b1) begin errors++; $display("FAIL rb_stall got %b want 1", retire_stall); end
    checks++; if (copy_map[7] !== 6'd50) begin errors++; $display("FAIL rb_map7 got %0d want 50", copy_map[7]); end
    checks++; if (copy_map[3] !== 6'd41) begin errors++; $display("FAIL rb_map3 got %0d want 41", copy_map[3]); end
    checks++; if (copy_map[5] !== 6'd35) begin errors++; $display("FAIL rb_map5 got %0d want 35", copy_map[5]); end
    checks++; if (free_valid !== 4'b0010) begin errors++; $display("FAIL rb_fv got %b want 0010", free_valid); end
    checks++; if (free_tag[1] !== 6'd7) begin errors++; $display("FAIL rb_ftag got %0d want 7", free_tag[1]); end
    snap = copy_map;
    clr(); lane(0, 9, 60); lane(1, 7, 61); rollback = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (copy_valid !== 1'b1) begin errors++; $display("FAIL hold_cv cyc %0d got %b want 1", k, copy_valid); end
      checks++; if (copy_map !== snap) begin errors++; $display("FAIL hold_map cyc %0d got %h want %h", k, copy_map, snap); end
      checks++; if (free_valid !== 4'b0000) begin errors++; $display("FAIL hold_fv cyc %0d got %b want 0000", k, free_valid); end
    end
    clr(); copy_ready = 1'b1; step();
    checks++; if (copy_valid !== 1'b0) begin errors++; $display("FAIL release_cv got %b want 0", copy_valid); end
    checks++; if (retire_stall !== 1'b0) begin errors++; $display("FAIL release_stall got %b want 0", retire_stall); end
    copy_ready = 1'b0; lane(0, 9, 62); lane(1, 7, 63); step();
    checks++; if (free_tag[0] !== 6'd9) begin errors++; $display("FAIL hold_ignored9 got %0d want 9", free_tag[0]); end
    checks++; if (free_tag[1] !== 6'd50) begin errors++; $display("FAIL hold_ignored7 got %0d want 50", free_tag[1]); end
    clr();
  endtask

  task automatic test_back_to_back();
    clr(); rollback = 1'b1; copy_ready = 1'b1; step();
    checks++; if (copy_valid !== 1'b1) begin errors++; $display("FAIL b2b_cv1 got %b want 1", copy_valid); end
    rollback = 1'b0; step();
    checks++; if (copy_valid !== 1'b0) begin errors++; $display("FAIL b2b_min_hold got %b want 0", copy_valid); end
    rollback = 1'b1; step();
    checks++; if (copy_valid !== 1'b1) begin errors++; $display("FAIL b2b_cv2 got %b want 1", copy_valid); end
    checks++; if (copy_map[9] !== 6'd62) begin errors++; $display("FAIL b2b_map9 got %0d want 62", copy_map[9]); end
    rollback = 1'b0; step();
    checks++; if (copy_valid !== 1'b0) begin errors++; $display("FAIL b2b_cv3 got %b want 0", copy_valid); end
    copy_ready = 1'b0; clr();
  endtask

  task automatic test_reset_in_hold();
    int bad;
    clr(); lane(0, 2, 45); rollback = 1'b1; step();
    checks++; if (copy_map[2] !== 6'd45) begin errors++; $display("FAIL rh_map2 got %0d want 45", copy_map[2]); end
    clr(); reset_n = 1'b0; step(); reset_n = 1'b1;
    checks++; if (copy_valid !== 1'b0) begin errors++; $display("FAIL rh_cv got %b want 0", copy_valid); end
    checks++; if (retire_stall !== 1'b0) begin errors++; $display("FAIL rh_stall got %b want 0", retire_stall); end
    checks++; if (free_valid !== 4'b0000) begin errors++; $display("FAIL rh_fv got %b want 0000", free_valid); end
    rollback = 1'b1; step();
    bad = 0;
    for (int i = 0; i < NA; i++) if (copy_map[i] !== PW'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rh_identity got %0d non-identity entries want 0", bad); end
    clr(); copy_ready = 1'b1; step(); copy_ready = 1'b0;
  endtask

  task automatic test_zero_reg();
    do_reset();
    lane(0, 0, 20); step();
`ifdef RRAT_ZERO_REG_EN
    checks++; if (free_valid !== 4'b0000) begin errors++; $display("FAIL zero_fv got %b want 0000", free_valid); end
`else
    checks++; if (free_valid !== 4'b0001) begin errors++; $display("FAIL zero_fv got %b want 0001", free_valid); end
    checks++; if (free_tag[0] !== 6'd0) begin errors++; $display("FAIL zero_ftag got %0d want 0", free_tag[0]); end
`endif
    clr(); rollback = 1'b1; step();
`ifdef RRAT_ZERO_REG_EN
    checks++; if (copy_map[0] !== 6'd0) begin errors++; $display("FAIL zero_map0 got %0d want 0", copy_map[0]); end
`else
    checks++; if (copy_map[0] !== 6'd20) begin errors++; $display("FAIL zero_map0 got %0d want 20", copy_map[0]); end
`endif
    clr(); copy_ready = 1'b1; step(); copy_ready = 1'b0;
  endtask

  task automatic test_random();
    int ref_map[NA];
    bit in_pool[64];
    int pool[$];
    bit exp_fv[SC];
    int exp_ft[SC];
    bit have_exp;
    int bad;
    do_reset();
    for (int i = 0; i < NA; i++) ref_map[i] = i;
    for (int t = 0; t < 64; t++) in_pool[t] = 1'b0;
    for (int t = NA; t < 64; t++) begin pool.push_back(t); in_pool[t] = 1'b1; end
    have_exp = 1'b0;
    for (int cyc = 0; cyc <= 200; cyc++) begin
      if (have_exp) begin
        for (int j = 0; j < SC; j++) begin
          checks++;
          if (free_valid[j] !== exp_fv[j]) begin
            errors++; $display("FAIL rnd_fv cyc %0d lane %0d got %b want %b", cyc, j, free_valid[j], exp_fv[j]);
          end else if (exp_fv[j] && free_tag[j] !== PW'(exp_ft[j])) begin
            errors++; $display("FAIL rnd_ftag cyc %0d lane %0d got %0d want %0d", cyc, j, free_tag[j], exp_ft[j]);
          end
          if (exp_fv[j] && free_valid[j] === 1'b1) begin
            checks++;
            if (in_pool[free_tag[j]]) begin
              errors++; $display("FAIL rnd_double_free cyc %0d lane %0d tag %0d got freed-again want not-free", cyc, j, free_tag[j]);
            end
          end
          if (exp_fv[j]) begin in_pool[exp_ft[j]] = 1'b1; pool.push_back(exp_ft[j]); end
        end
      end
      clr();
      have_exp = 1'b0;
      for (int j = 0; j < SC; j++) begin exp_fv[j] = 1'b0; exp_ft[j] = 0; end
      if (cyc < 200) begin
        have_exp = 1'b1;
        for (int j = 0; j < SC; j++) begin
          if ($urandom_range(3, 0) != 0 && pool.size() > 0) begin
            int a, t;
            a = $urandom_range(7, 0);
            t = pool.pop_front();
            in_pool[t] = 1'b0;
            lane(j, a, t);
`ifdef RRAT_ZERO_REG_EN
            if (a == 0) begin
              in_pool[t] = 1'b1; pool.push_back(t);
              continue;
            end
`endif
            exp_fv[j] = 1'b1;
            exp_ft[j] = ref_map[a];
            ref_map[a] = t;
          end
        end
      end
      step();
    end
    clr(); rollback = 1'b1; step();
    bad = 0;
    for (int i = 0; i < NA; i++) if (copy_map[i] !== PW'(ref_map[i])) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rnd_final_map got %0d differing entries want 0", bad); end
    clr(); copy_ready = 1'b1; step(); copy_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_reg();
    test_rollback();
    test_back_to_back();
    test_reset_in_hold();
    test_zero_reg();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
